chip8_bus_master: RTL and testbench

//  Initiator side of the shared byte-wide memory bus (address, write, select, tri-state data) that the RAM

---
 rtl/chip8_bus_pkg.sv | 39 +++
 rtl/chip8_bus_if.sv | 52 +++++
 rtl/chip8_bus_master.sv | 177 +++++++++++++++++
 tb/tb_chip8_bus_master.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_bus_pkg.sv
// ---------------------------------------------------------------------------
// chip8_bus_pkg
// Shared types and sizes for the Chip-8 byte-wide memory bus master.
//   op_t       request opcode encoding seen on the request port
//   state_t    bus master sequencing states
//   clamp_len  limits a requested burst length to MAX_LEN
// ---------------------------------------------------------------------------
package chip8_bus_pkg;

    localparam int unsigned DEFAULT_BITS = 12;
    localparam int unsigned MAX_LEN      = 16;
    localparam int unsigned LEN_W        = 5;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned OPCODE_W     = 16;
    localparam int unsigned OP_W         = 2;

    // Encoding 2'b11 is reserved and executes as a READ.
    typedef enum logic [OP_W-1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_FETCH16 = 2'b10
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_FETCH_LO = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    // Bursts longer than the supported maximum are shortened, not rejected.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

endpackage : chip8_bus_pkg

// File: rtl/chip8_bus_if.sv
// ---------------------------------------------------------------------------
// chip8_bus_if
// Groups the CPU request/stream handshake and the RAM control lines of the
// Chip-8 memory bus. The tri-state data lines are not part of the bundle;
// they are a plain inout on the master.
//   request  : req, op, addr, len            (CPU -> master)
//   status   : busy, done, opcode            (master -> CPU)
//   read     : rdata, rdata_valid, rdata_idx (master -> CPU)
//   write    : wdata, wdata_valid, wdata_ready
//   ram ctrl : bus_address, bus_write, bus_select (master -> RAM)
// Modports: master (the bus master), slave (CPU core and RAM side).
// ---------------------------------------------------------------------------
interface chip8_bus_if
    import chip8_bus_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) ();

    logic                req;
    logic [OP_W-1:0]     op;
    logic [BITS-1:0]     addr;
    logic [LEN_W-1:0]    len;

    logic                busy;
    logic                done;
    logic [OPCODE_W-1:0] opcode;

    logic [DATA_W-1:0]   rdata;
    logic                rdata_valid;
    logic [IDX_W-1:0]    rdata_idx;

    logic [DATA_W-1:0]   wdata;
    logic                wdata_valid;
    logic                wdata_ready;

    logic [BITS-1:0]     bus_address;
    logic                bus_write;
    logic                bus_select;

    modport master (
        input  req, op, addr, len, wdata, wdata_valid,
        output busy, done, opcode, rdata, rdata_valid, rdata_idx, wdata_ready,
        output bus_address, bus_write, bus_select
    );

    modport slave (
        output req, op, addr, len, wdata, wdata_valid,
        input  busy, done, opcode, rdata, rdata_valid, rdata_idx, wdata_ready,
        input  bus_address, bus_write, bus_select
    );

endinterface : chip8_bus_if

// File: rtl/chip8_bus_master.sv
// ---------------------------------------------------------------------------
// chip8_bus_master
// Initiator of the shared byte-wide Chip-8 memory bus. Converts CPU requests
// into bus cycles: 16-bit opcode fetch, byte read bursts and byte write
// bursts. It is the only driver of bus_address, bus_write and bus_select.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset; releases the bus at once
//   bus       chip8_bus_if.master: request, status, read/write streams and
//             the RAM control lines
//   bus_data  tri-state data lines; driven with wdata only during a write
//             beat, otherwise high impedance so the RAM can drive them
// ---------------------------------------------------------------------------
module chip8_bus_master
    import chip8_bus_pkg::*;
#(
    parameter int unsigned BITS = DEFAULT_BITS
) (
    input  logic              clk,
    input  logic              reset,
    chip8_bus_if.master       bus,
    inout  wire  [DATA_W-1:0] bus_data
);

    // Sequencing and transaction context
    state_t              state_q, state_d;
    logic [BITS-1:0]     cur_q, cur_d;
    logic [LEN_W-1:0]    n_q, n_d;
    logic [LEN_W-1:0]    beat_q, beat_d;
    logic [DATA_W-1:0]   hi_q, hi_d;

    // CPU-facing result registers
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rdata_valid_q, rdata_valid_d;
    logic [IDX_W-1:0]    rdata_idx_q, rdata_idx_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;

    // Bus control decoded from the current state
    logic                select_c;
    logic                write_c;
    logic [BITS-1:0]     address_c;
    logic                ready_c;

    logic [LEN_W-1:0]    len_clamped;
    logic                last_beat;

    assign len_clamped = clamp_len(bus.len);
    assign last_beat   = (beat_q == (n_q - LEN_W'(1)));

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cur_q         <= '0;
            n_q           <= '0;
            beat_q        <= '0;
            hi_q          <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rdata_idx_q   <= '0;
            opcode_q      <= '0;
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            n_q           <= n_d;
            beat_q        <= beat_d;
            hi_q          <= hi_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_idx_q   <= rdata_idx_d;
            opcode_q      <= opcode_d;
        end
    end

    // Next-state, datapath update and bus control
    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        n_d           = n_q;
        beat_d        = beat_q;
        hi_d          = hi_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        rdata_idx_d   = rdata_idx_q;
        opcode_d      = opcode_q;
        select_c      = 1'b0;
        write_c       = 1'b0;
        address_c     = '0;
        ready_c       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    cur_d  = bus.addr;
                    n_d    = len_clamped;
                    beat_d = '0;
                    // FETCH16 ignores len; empty READ/WRITE bursts skip the bus.
                    if (bus.op == OP_FETCH16) begin
                        state_d = ST_FETCH_HI;
                    end else if (len_clamped == '0) begin
                        state_d = ST_DONE;
                    end else if (bus.op == OP_WRITE) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                // RAM drives bus_data this cycle; the byte is presented next cycle.
                select_c      = 1'b1;
                address_c     = cur_q;
                rdata_d       = bus_data;
                rdata_valid_d = 1'b1;
                rdata_idx_d   = IDX_W'(beat_q);
                cur_d         = cur_q + BITS'(1);
                beat_d        = beat_q + LEN_W'(1);
                if (last_beat) begin
                    state_d = ST_DONE;
                end
            end

            ST_WRITE: begin
                // A missing wdata stalls the burst with the bus idle.
                ready_c = 1'b1;
                if (bus.wdata_valid) begin
                    write_c   = 1'b1;
                    address_c = cur_q;
                    cur_d     = cur_q + BITS'(1);
                    beat_d    = beat_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_FETCH_HI: begin
                select_c  = 1'b1;
                address_c = cur_q;
                hi_d      = bus_data;
                cur_d     = cur_q + BITS'(1);
                state_d   = ST_FETCH_LO;
            end

            ST_FETCH_LO: begin
                select_c  = 1'b1;
                address_c = cur_q;
                opcode_d  = {hi_q, bus_data};
                state_d   = ST_DONE;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.wdata_ready = ready_c;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.rdata_idx   = rdata_idx_q;
    assign bus.opcode      = opcode_q;
    assign bus.bus_select  = select_c;
    assign bus.bus_write   = write_c;
    assign bus.bus_address = address_c;

    // Data lines are driven only during a write beat.
    assign bus_data = write_c ? bus.wdata : {DATA_W{1'bz}};

endmodule : chip8_bus_master

// File: tb/tb_chip8_bus_master.sv
// ---------------------------------------------------------------------------
// tb_chip8_bus_master
// Self-checking bench for chip8_bus_master with a behavioural RAM on the
// tri-state bus and a reference memory image used to predict every result.
// ---------------------------------------------------------------------------
module tb_chip8_bus_master;
    import chip8_bus_pkg::*;

    localparam int unsigned BITS  = DEFAULT_BITS;
    localparam int unsigned DEPTH = 1 << BITS;
    localparam int unsigned AMASK = DEPTH - 1;

    logic clk;
    logic reset;
    logic load_req;

    chip8_bus_if #(.BITS(BITS)) bus ();
    wire [DATA_W-1:0] bus_data;

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] wbuf    [MAX_LEN];

    int n_checks;
    int n_fail;

    // Monitor state (written only by the monitor)
    int          cyc;
    int          done_cnt;
    int          done_cyc;
    int          contention;
    int unsigned sel_addr_q[$];
    int unsigned sel_cyc_q[$];
    int unsigned wr_addr_q[$];
    int unsigned wr_data_q[$];
    int unsigned rd_idx_q[$];
    int unsigned rd_data_q[$];
    int unsigned rd_cyc_q[$];

    int b_sel, b_wr, b_rd, b_done;

    chip8_bus_master #(.BITS(BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .bus_data (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Initial RAM image: font digits 0/1 at 0x000, program word 0x124E at 0x200.
    function automatic logic [7:0] init_byte(input int unsigned a);
        case (a)
            0, 4:          return 8'hF0;
            1, 2, 3:       return 8'h90;
            5, 7, 8:       return 8'h20;
            6:             return 8'h60;
            9:             return 8'h70;
            'h200:         return 8'h12;
            'h201:         return 8'h4E;
            default:       return 8'(a * 37 + 11);
        endcase
    endfunction

    // RAM: drives data while selected, captures on write
    assign bus_data = (bus.bus_select && !bus.bus_write) ? mem[bus.bus_address] : 8'bz;
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_byte(i);
        end else if (bus.bus_write) begin
            mem[bus.bus_address] <= bus_data;
        end
    end

    // Bus/stream monitor
    always @(negedge clk) begin
        cyc++;
        if (bus.bus_select && bus.bus_write) contention++;
        if (bus.bus_select) begin
            sel_addr_q.push_back(bus.bus_address);
            sel_cyc_q.push_back(cyc);
        end
        if (bus.bus_write) begin
            wr_addr_q.push_back(bus.bus_address);
            wr_data_q.push_back(bus_data);
        end
        if (bus.rdata_valid) begin
            rd_idx_q.push_back(bus.rdata_idx);
            rd_data_q.push_back(bus.rdata);
            rd_cyc_q.push_back(cyc);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic snapshot();
        b_sel  = sel_addr_q.size();
        b_wr   = wr_addr_q.size();
        b_rd   = rd_data_q.size();
        b_done = done_cnt;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == b_done && t < 100) begin
            @(negedge clk); #1;
            t++;
        end
        n_checks++;
        if (done_cnt == b_done) begin
            n_fail++;
            $display("FAIL done_timeout: no done after %0d cycles", t);
        end
        @(posedge clk); #1;
    endtask

    // Drive one transaction; writes stream wbuf with random stalls plus an optional forced stall.
    task automatic issue(input logic [1:0] op, input logic [BITS-1:0] a, input logic [LEN_W-1:0] l,
                         input int unsigned stall_max, input int stall_at, input int stall_len);
        int n;
        n = (l > MAX_LEN) ? MAX_LEN : int'(l);
        snapshot();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = op; bus.addr = a; bus.len = l;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.op = 2'($urandom); bus.addr = BITS'($urandom); bus.len = LEN_W'($urandom);
        if (op == 2'b01) begin
            for (int i = 0; i < n; i++) begin
                repeat ((i == stall_at) ? stall_len : int'($urandom_range(stall_max, 0))) begin
                    bus.wdata = 8'($urandom); bus.wdata_valid = 1'b0;
                    @(posedge clk); #1;
                end
                bus.wdata = wbuf[i]; bus.wdata_valid = 1'b1;
                @(posedge clk); #1;
            end
            bus.wdata_valid = 1'b0;
        end
        wait_done();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.rdata_valid, bus.wdata_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_status: busy/done/rvalid/ready=%b required 0000",
                     {bus.busy, bus.done, bus.rdata_valid, bus.wdata_ready});
        end
        n_checks++;
        if ({bus.rdata, bus.rdata_idx, bus.opcode} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h idx=%h opcode=%h required 0", bus.rdata, bus.rdata_idx, bus.opcode);
        end
        n_checks++;
        if ({bus.bus_select, bus.bus_write, bus.bus_address} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_bus: sel=%b wr=%b addr=%h required 0", bus.bus_select, bus.bus_write, bus.bus_address);
        end
        load_req = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic test_fetch();
        issue(2'b10, 12'h200, 5'd7, 0, -1, 0);
        n_checks++;
        if (bus.opcode !== 16'h124E) begin
            n_fail++; $display("FAIL fetch_opcode: got %h required 124e", bus.opcode);
        end
        n_checks++;
        if (sel_addr_q.size() - b_sel != 2) begin
            n_fail++; $display("FAIL fetch_select_cycles: got %0d required 2", sel_addr_q.size() - b_sel);
        end else begin
            n_checks++;
            if (sel_addr_q[b_sel] != 'h200 || sel_addr_q[b_sel+1] != 'h201 ||
                sel_cyc_q[b_sel+1] != sel_cyc_q[b_sel] + 1) begin
                n_fail++;
                $display("FAIL fetch_addresses: got %h,%h required 200,201 consecutive",
                         sel_addr_q[b_sel], sel_addr_q[b_sel+1]);
            end
        end
        n_checks++;
        if (done_cnt - b_done != 1 || rd_data_q.size() != b_rd) begin
            n_fail++;
            $display("FAIL fetch_done_rvalid: done=%0d rvalid=%0d required 1,0", done_cnt - b_done, rd_data_q.size() - b_rd);
        end
        // A read must not disturb the held opcode.
        issue(2'b00, 12'h020, 5'd3, 0, -1, 0);
        n_checks++;
        if (bus.opcode !== 16'h124E) begin
            n_fail++; $display("FAIL fetch_opcode_held: got %h required 124e", bus.opcode);
        end
    endtask

    task automatic test_read();
        logic [7:0] exp [5];
        exp = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0};
        issue(2'b00, 12'h000, 5'd5, 0, -1, 0);
        n_checks++;
        if (rd_data_q.size() - b_rd != 5 || sel_addr_q.size() - b_sel != 5) begin
            n_fail++;
            $display("FAIL read_count: rvalid=%0d sel=%0d required 5,5", rd_data_q.size() - b_rd, sel_addr_q.size() - b_sel);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rd_data_q[b_rd+i] != exp[i] || rd_idx_q[b_rd+i] != i ||
                    (i > 0 && rd_cyc_q[b_rd+i] != rd_cyc_q[b_rd+i-1] + 1)) begin
                    n_fail++;
                    $display("FAIL read_beat%0d: data=%h idx=%0d required %h idx %0d on consecutive cycles",
                             i, rd_data_q[b_rd+i], rd_idx_q[b_rd+i], exp[i], i);
                end
            end
            n_checks++;
            if (done_cyc != int'(rd_cyc_q[b_rd+4])) begin
                n_fail++; $display("FAIL read_done_align: done cycle %0d required %0d", done_cyc, rd_cyc_q[b_rd+4]);
            end
        end
    endtask

    task automatic test_write_stall();
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        issue(2'b01, 12'h3E8, 5'd3, 0, 1, 2);
        n_checks++;
        if (wr_addr_q.size() - b_wr != 3) begin
            n_fail++; $display("FAIL write_beats: got %0d required 3", wr_addr_q.size() - b_wr);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_addr_q[b_wr+i] != 'h3E8 + i || wr_data_q[b_wr+i] != i + 1) begin
                    n_fail++;
                    $display("FAIL write_beat%0d: addr=%h data=%h required %h %h",
                             i, wr_addr_q[b_wr+i], wr_data_q[b_wr+i], 'h3E8 + i, i + 1);
                end
            end
        end
        for (int i = 0; i < 3; i++) ref_mem['h3E8 + i] = wbuf[i];
        issue(2'b00, 12'h3E8, 5'd3, 0, -1, 0);
        for (int i = 0; i < 3 && b_rd + i < rd_data_q.size(); i++) begin
            n_checks++;
            if (rd_data_q[b_rd+i] != i + 1) begin
                n_fail++; $display("FAIL write_readback%0d: got %h required %h", i, rd_data_q[b_rd+i], i + 1);
            end
        end
    endtask

    task automatic test_wrap();
        issue(2'b00, 12'hFFF, 5'd2, 0, -1, 0);
        n_checks++;
        if (sel_addr_q.size() - b_sel != 2 || sel_addr_q[b_sel] != 'hFFF || sel_addr_q[b_sel+1] != 'h000) begin
            n_fail++; $display("FAIL wrap_addresses: count=%0d required FFF then 000", sel_addr_q.size() - b_sel);
        end
        n_checks++;
        if (rd_data_q.size() - b_rd != 2 || rd_data_q[b_rd] != ref_mem['hFFF] || rd_data_q[b_rd+1] != 8'hF0) begin
            n_fail++; $display("FAIL wrap_data: count=%0d required %h,f0", rd_data_q.size() - b_rd, ref_mem['hFFF]);
        end
    endtask

    task automatic test_len0();
        snapshot();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = 2'b01; bus.addr = 12'h123; bus.len = 5'd0; bus.wdata_valid = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done, bus.bus_write, bus.wdata_ready} !== 4'b1100) begin
            n_fail++;
            $display("FAIL len0_done: busy/done/write/ready=%b required 1100",
                     {bus.busy, bus.done, bus.bus_write, bus.wdata_ready});
        end
        @(posedge clk); #1;
        bus.wdata_valid = 1'b0;
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00 || wr_addr_q.size() != b_wr || sel_addr_q.size() != b_sel) begin
            n_fail++;
            $display("FAIL len0_idle: busy=%b done=%b writes=%0d selects=%0d required 0,0,0,0",
                     bus.busy, bus.done, wr_addr_q.size() - b_wr, sel_addr_q.size() - b_sel);
        end
    endtask

    task automatic test_back_to_back();
        int t = 0;
        snapshot();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = 2'b00; bus.addr = 12'h100; bus.len = 5'd2;
        while (done_cnt == b_done && t < 50) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        b_done = b_done + 1;
        wait_done();
        n_checks++;
        if (sel_cyc_q.size() - b_sel != 4) begin
            n_fail++; $display("FAIL b2b_selects: got %0d required 4", sel_cyc_q.size() - b_sel);
        end else begin
            n_checks++;
            if (sel_cyc_q[b_sel+1] - sel_cyc_q[b_sel] != 1 || sel_cyc_q[b_sel+2] - sel_cyc_q[b_sel+1] != 3) begin
                n_fail++;
                $display("FAIL b2b_gap: gap=%0d required 3", sel_cyc_q[b_sel+2] - sel_cyc_q[b_sel+1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t = 0;
        snapshot();
        @(posedge clk); #1;
        bus.req = 1'b1; bus.op = 2'b00; bus.addr = 12'h010; bus.len = 5'd5;
        @(posedge clk); #1;
        bus.req = 1'b0;
        while (rd_data_q.size() - b_rd < 2 && t < 20) begin @(negedge clk); #1; t++; end
        n_checks++;
        if (bus.bus_select !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_pre: sel=%b busy=%b required 1,1", bus.bus_select, bus.busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.bus_select, bus.bus_write, bus.busy, bus.done, bus.rdata_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: sel/wr/busy/done/rvalid=%b required 00000",
                     {bus.bus_select, bus.bus_write, bus.busy, bus.done, bus.rdata_valid});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        n_checks++;
        if (done_cnt != b_done) begin
            n_fail++; $display("FAIL rst_mid_done: got %0d done pulses required 0", done_cnt - b_done);
        end
        issue(2'b00, 12'h000, 5'd5, 0, -1, 0);
        n_checks++;
        if (rd_data_q.size() - b_rd != 5 || rd_data_q[b_rd] != 8'hF0 || rd_data_q[b_rd+1] != 8'h90) begin
            n_fail++; $display("FAIL rst_mid_after: count=%0d required 5 starting f0,90", rd_data_q.size() - b_rd);
        end
    endtask

    task automatic test_random();
        logic [1:0]       op;
        logic [BITS-1:0]  a;
        logic [LEN_W-1:0] l;
        int               n;
        logic [15:0]      exp_op;
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom);
            a  = ($urandom_range(3, 0) == 0) ? BITS'(AMASK - $urandom_range(3, 0)) : BITS'($urandom);
            l  = LEN_W'($urandom_range(20, 0));
            n  = (l > MAX_LEN) ? MAX_LEN : int'(l);
            for (int i = 0; i < MAX_LEN; i++) wbuf[i] = 8'($urandom);
            issue(op, a, l, 2, -1, 0);
            n_checks++;
            if (done_cnt - b_done != 1) begin
                n_fail++; $display("FAIL rnd%0d_done: got %0d pulses required 1", k, done_cnt - b_done);
            end
            if (op == 2'b10) begin
                exp_op = {ref_mem[a], ref_mem[(int'(a) + 1) & AMASK]};
                n_checks++;
                if (bus.opcode !== exp_op || sel_addr_q.size() - b_sel != 2) begin
                    n_fail++;
                    $display("FAIL rnd%0d_fetch: opcode=%h sel=%0d required %h, 2",
                             k, bus.opcode, sel_addr_q.size() - b_sel, exp_op);
                end
            end else if (op == 2'b01) begin
                n_checks++;
                if (wr_addr_q.size() - b_wr != n || sel_addr_q.size() != b_sel) begin
                    n_fail++;
                    $display("FAIL rnd%0d_wcount: writes=%0d selects=%0d required %0d,0",
                             k, wr_addr_q.size() - b_wr, sel_addr_q.size() - b_sel, n);
                end
                for (int i = 0; i < n && b_wr + i < wr_addr_q.size(); i++) begin
                    n_checks++;
                    if (wr_addr_q[b_wr+i] != ((int'(a) + i) & AMASK) || wr_data_q[b_wr+i] != wbuf[i]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_wbeat%0d: addr=%h data=%h required %h %h", k, i,
                                 wr_addr_q[b_wr+i], wr_data_q[b_wr+i], (int'(a) + i) & AMASK, wbuf[i]);
                    end
                end
                for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) & AMASK] = wbuf[i];
            end else begin
                n_checks++;
                if (rd_data_q.size() - b_rd != n || sel_addr_q.size() - b_sel != n) begin
                    n_fail++;
                    $display("FAIL rnd%0d_rcount: rvalid=%0d sel=%0d required %0d",
                             k, rd_data_q.size() - b_rd, sel_addr_q.size() - b_sel, n);
                end
                for (int i = 0; i < n && b_rd + i < rd_data_q.size(); i++) begin
                    n_checks++;
                    if (rd_idx_q[b_rd+i] != i || rd_data_q[b_rd+i] != ref_mem[(int'(a) + i) & AMASK]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_rbeat%0d: idx=%0d data=%h required %0d %h", k, i,
                                 rd_idx_q[b_rd+i], rd_data_q[b_rd+i], i, ref_mem[(int'(a) + i) & AMASK]);
                    end
                end
            end
        end
        n_checks++;
        if (contention != 0) begin
            n_fail++; $display("FAIL bus_contention: %0d cycles with select and write both high, required 0", contention);
        end
    endtask

    initial begin
        reset           = 1'b0;
        load_req        = 1'b1;
        bus.req         = 1'b0;
        bus.op          = 2'b00;
        bus.addr        = '0;
        bus.len         = '0;
        bus.wdata       = '0;
        bus.wdata_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);

        test_reset();
        test_fetch();
        test_read();
        test_write_stall();
        test_wrap();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_chip8_bus_master
